// File: rtl/input_cond.sv
// Multi-channel input conditioner: synchroniser chain, per-channel debounce, edge pulses.
// Latency: a stable input reaches out after SYNC_STAGES+DEBOUNCE edges, and its rise/fall pulse comes on the same edge.
// Backpressure: none; the block is free-running and samples every cycle.
module input_cond #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A channel's count only advances while its synchronised level disagrees with out;
    // any agreement drops it back to zero so a new mismatch must restart the full run.
    always_comb begin
        out_nxt  = out;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync[i] != out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    out_nxt[i]  = sync[i];
                    rise_nxt[i] = sync[i];
                    fall_nxt[i] = ~sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            out      <= '0;
            rise     <= '0;
            fall     <= '0;
            any_edge <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            out      <= out_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            any_edge <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_input_cond.sv
// Bench for input_cond: a default build (DEBOUNCE=4) and a DEBOUNCE=1 build share the same inputs.
module tb_input_cond;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int DA = 4;
    localparam int DB = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in  = '0;

    logic [W-1:0] out_a, rise_a, fall_a;
    logic [W-1:0] out_b, rise_b, fall_b;
    logic         any_a, any_b;

    int total = 0;
    int bad   = 0;

    // Model state: the raw input sampled at every edge since reset release,
    // and per build the expected out level and this cycle's pulses.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_out  [2];
    logic [W-1:0] m_rise [2];
    logic [W-1:0] m_fall [2];
    int           dep    [2];

    input_cond #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(DA)) dut_a (
        .clk(clk), .rst(rst), .in(in),
        .out(out_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a)
    );

    input_cond #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(DB)) dut_b (
        .clk(clk), .rst(rst), .in(in),
        .out(out_b), .rise(rise_b), .fall(fall_b), .any_edge(any_b)
    );

    always #5 clk = ~clk;

    wire [3*W:0] va = {out_a, rise_a, fall_a, any_a};
    wire [3*W:0] vb = {out_b, rise_b, fall_b, any_b};

    function automatic logic [3*W:0] exp_vec(int k);
        return {m_out[k], m_rise[k], m_fall[k], |(m_rise[k] | m_fall[k])};
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = '0;
            m_rise[k] = '0;
            m_fall[k] = '0;
        end
    endtask

    // True when the input seen by the synchroniser output has sat at 'want'
    // for the last d edges (edge n uses the input sampled S edges earlier).
    function automatic bit settled(int ch, int d, logic want);
        int n = hist.size();
        for (int j = 0; j < d; j++) begin
            int   idx = n - 1 - S - j;
            logic v   = (idx < 0) ? 1'b0 : hist[idx][ch];
            if (v != want) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic [W-1:0] nxt;
        hist.push_back(in);
        for (int k = 0; k < 2; k++) begin
            nxt = m_out[k];
            for (int i = 0; i < W; i++) begin
                if (settled(i, dep[k], ~m_out[k][i])) nxt[i] = ~m_out[k][i];
            end
            m_rise[k] = nxt & ~m_out[k];
            m_fall[k] = ~nxt & m_out[k];
            m_out[k]  = nxt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in  = 4'b1111;
        #1;
        model_clear();
        total++;
        if (va !== '0 || vb !== '0) begin
            bad++;
            $display("FAIL reset_async a=%h b=%h want 0", va, vb);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (va !== '0 || vb !== '0) begin
                bad++;
                $display("FAIL reset_held cyc=%0d a=%h b=%h want 0", c, va, vb);
            end
        end
    endtask

    task automatic test_release();
        logic [3*W:0] want;
        in  = 4'b0001;
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       want = '0;
            else if (e == 6) want = {4'b0001, 4'b0001, 4'b0000, 1'b1};
            else             want = {4'b0001, 4'b0000, 4'b0000, 1'b0};
            total++;
            if (va !== want) begin
                bad++;
                $display("FAIL release_a edge=%0d got=%h want=%h", e, va, want);
            end
            total++;
            if (vb !== exp_vec(1)) begin
                bad++;
                $display("FAIL release_b edge=%0d got=%h want=%h", e, vb, exp_vec(1));
            end
        end
    endtask

    task automatic test_glitch();
        in = 4'b0000;
        for (int e = 0; e < 11; e++) begin
            if (e == 3) in = 4'b0001;
            step();
            total++;
            if ({out_a, fall_a} !== {4'b0001, 4'b0000}) begin
                bad++;
                $display("FAIL glitch_a edge=%0d out=%b fall=%b want out=0001 fall=0000", e, out_a, fall_a);
            end
            total++;
            if (vb !== exp_vec(1)) begin
                bad++;
                $display("FAIL glitch_b edge=%0d got=%h want=%h", e, vb, exp_vec(1));
            end
        end
    endtask

    task automatic test_multi();
        logic [3*W:0] want;
        in = 4'b0110;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       want = {4'b0001, 4'b0000, 4'b0000, 1'b0};
            else if (e == 6) want = {4'b0110, 4'b0110, 4'b0001, 1'b1};
            else             want = {4'b0110, 4'b0000, 4'b0000, 1'b0};
            total++;
            if (va !== want) begin
                bad++;
                $display("FAIL multi_a edge=%0d got=%h want=%h", e, va, want);
            end
            total++;
            if (vb !== exp_vec(1)) begin
                bad++;
                $display("FAIL multi_b edge=%0d got=%h want=%h", e, vb, exp_vec(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3*W:0] want;
        in = 4'b1110;
        for (int e = 1; e <= 4; e++) begin
            step();
            total++;
            if (va !== {4'b0110, 4'b0000, 4'b0000, 1'b0}) begin
                bad++;
                $display("FAIL midrst_pre edge=%0d got=%h want out=0110 no pulses", e, va);
            end
        end
        rst = 1'b0;
        #1;
        model_clear();
        total++;
        if (va !== '0 || vb !== '0) begin
            bad++;
            $display("FAIL midrst_async a=%h b=%h want 0", va, vb);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            total++;
            if (va !== '0 || vb !== '0) begin
                bad++;
                $display("FAIL midrst_held cyc=%0d a=%h b=%h want 0", e, va, vb);
            end
        end
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6)       want = '0;
            else if (e == 6) want = {4'b1110, 4'b1110, 4'b0000, 1'b1};
            else             want = {4'b1110, 4'b0000, 4'b0000, 1'b0};
            total++;
            if (va !== want) begin
                bad++;
                $display("FAIL midrst_post edge=%0d got=%h want=%h", e, va, want);
            end
        end
    endtask

    task automatic test_debounce1();
        logic [3*W:0] want;
        in  = 4'b0000;
        rst = 1'b0;
        #1;
        model_clear();
        step();
        rst = 1'b1;
        for (int e = 0; e < 4; e++) step();
        in = 4'b0001;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e < 3)       want = '0;
            else if (e == 3) want = {4'b0001, 4'b0001, 4'b0000, 1'b1};
            else             want = {4'b0001, 4'b0000, 4'b0000, 1'b0};
            total++;
            if (vb !== want) begin
                bad++;
                $display("FAIL deb1 edge=%0d got=%h want=%h", e, vb, want);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] one = 1;
        int           r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r == 0)     in = W'($urandom);
            else if (r < 3) in = in ^ (one << $urandom_range(0, W-1));
            step();
            total++;
            if (va !== exp_vec(0)) begin
                bad++;
                $display("FAIL rand_a cyc=%0d got=%h want=%h", c, va, exp_vec(0));
            end
            total++;
            if (vb !== exp_vec(1)) begin
                bad++;
                $display("FAIL rand_b cyc=%0d got=%h want=%h", c, vb, exp_vec(1));
            end
            total++;
            if (((rise_a & fall_a) | (rise_b & fall_b)) !== '0) begin
                bad++;
                $display("FAIL rand_excl cyc=%0d a=%b/%b b=%b/%b want disjoint", c, rise_a, fall_a, rise_b, fall_b);
            end
        end
    endtask

    initial begin
        dep[0] = DA;
        dep[1] = DB;
        model_clear();
        #2;
        test_reset();
        test_release();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_debounce1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
